// File: rtl/imm_pack.sv
// imm_pack: packs opcode, register/function fields and a full-width
// immediate into a 32-bit RV instruction word. Stage 1 classifies the
// opcode and range-checks the immediate; stage 2 assembles the bits.
// Errored results are delivered as inst=0, err=1 and counted.
module imm_pack #(
  parameter int INST_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_imm_pack_valid,
  output logic                     o_imm_pack_ready,
  input  logic [6:0]               i_imm_pack_opcode,
  input  logic [4:0]               i_imm_pack_rd,
  input  logic [4:0]               i_imm_pack_rs1,
  input  logic [4:0]               i_imm_pack_rs2,
  input  logic [2:0]               i_imm_pack_funct3,
  input  logic [DATA_WIDTH-1:0]    i_imm_pack_imm,
  output logic                     o_imm_pack_valid,
  input  logic                     i_imm_pack_ready,
  output logic [INST_WIDTH-1:0]    o_imm_pack_inst,
  output logic                     o_imm_pack_err,
  output logic [ERR_CNT_WIDTH-1:0] o_imm_pack_err_cnt
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_X = 3'd5
  } fmt_e;

  // True when v equals the sign-extension of its low n bits.
  function automatic logic fits(input logic [DATA_WIDTH-1:0] v, input int n);
    logic signed [DATA_WIDTH-1:0] t;
    t = $signed(v << (DATA_WIDTH - n));
    t = t >>> (DATA_WIDTH - n);
    return (t == $signed(v));
  endfunction

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Stage 1 state
  logic        s1_valid_r;
  logic [6:0]  s1_opcode_r;
  logic [4:0]  s1_rd_r;
  logic [4:0]  s1_rs1_r;
  logic [4:0]  s1_rs2_r;
  logic [2:0]  s1_funct3_r;
  logic [31:0] s1_imm_r;
  fmt_e        s1_fmt_r;
  logic        s1_err_r;

  // Stage 2 state (drives the outputs directly)
  logic                     s2_valid_r;
  logic [INST_WIDTH-1:0]    s2_inst_r;
  logic                     s2_err_r;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  // Handshake and combinational helpers
  logic                  s2_adv_s;
  logic                  s1_adv_s;
  fmt_e                  fmt_s;
  logic                  err_s;
  logic [INST_WIDTH-1:0] pack_s;

  assign s2_adv_s         = !s2_valid_r || i_imm_pack_ready;
  assign s1_adv_s         = !s1_valid_r || s2_adv_s;
  assign o_imm_pack_ready = s1_adv_s;

  assign o_imm_pack_valid   = s2_valid_r;
  assign o_imm_pack_inst    = s2_inst_r;
  assign o_imm_pack_err     = s2_err_r;
  assign o_imm_pack_err_cnt = err_cnt_r;

  // Classify the incoming opcode and check the immediate fits its format.
  always_comb begin
    fmt_s = FMT_X;
    err_s = 1'b1;
    case (i_imm_pack_opcode)
      7'b1100111, 7'b0000011, 7'b0010011: fmt_s = FMT_I;
      7'b0100011:                         fmt_s = FMT_S;
      7'b1100011:                         fmt_s = FMT_B;
      7'b0110111, 7'b0010111:             fmt_s = FMT_U;
      7'b1101111:                         fmt_s = FMT_J;
      default:                            fmt_s = FMT_X;
    endcase
    case (fmt_s)
      FMT_I, FMT_S: err_s = !fits(i_imm_pack_imm, 12);
      FMT_B:        err_s = !fits(i_imm_pack_imm, 13) || i_imm_pack_imm[0];
      FMT_J:        err_s = !fits(i_imm_pack_imm, 21) || i_imm_pack_imm[0];
      FMT_U:        err_s = (i_imm_pack_imm[11:0] != 12'd0) || !fits(i_imm_pack_imm, 32);
      default:      err_s = 1'b1;
    endcase
  end

  // Assemble the instruction word from the stage 1 fields; errors pack to 0.
  always_comb begin
    pack_s = {INST_WIDTH{1'b0}};
    if (s1_err_r) begin
      pack_s = {INST_WIDTH{1'b0}};
    end else begin
      case (s1_fmt_r)
        FMT_I: pack_s = {s1_imm_r[11:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
        FMT_S: pack_s = {s1_imm_r[11:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                         s1_imm_r[4:0], s1_opcode_r};
        FMT_B: pack_s = {s1_imm_r[12], s1_imm_r[10:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                         s1_imm_r[4:1], s1_imm_r[11], s1_opcode_r};
        FMT_U: pack_s = {s1_imm_r[31:12], s1_rd_r, s1_opcode_r};
        FMT_J: pack_s = {s1_imm_r[20], s1_imm_r[10:1], s1_imm_r[11], s1_imm_r[19:12],
                         s1_rd_r, s1_opcode_r};
        default: pack_s = {INST_WIDTH{1'b0}};
      endcase
    end
  end

  // Stage 1: capture request fields, format and error flag on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_r  <= 1'b0;
      s1_opcode_r <= 7'd0;
      s1_rd_r     <= 5'd0;
      s1_rs1_r    <= 5'd0;
      s1_rs2_r    <= 5'd0;
      s1_funct3_r <= 3'd0;
      s1_imm_r    <= 32'd0;
      s1_fmt_r    <= FMT_X;
      s1_err_r    <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= i_imm_pack_valid;
      if (i_imm_pack_valid) begin
        s1_opcode_r <= i_imm_pack_opcode;
        s1_rd_r     <= i_imm_pack_rd;
        s1_rs1_r    <= i_imm_pack_rs1;
        s1_rs2_r    <= i_imm_pack_rs2;
        s1_funct3_r <= i_imm_pack_funct3;
        s1_imm_r    <= i_imm_pack_imm[31:0];
        s1_fmt_r    <= fmt_s;
        s1_err_r    <= err_s;
      end
    end
  end

  // Stage 2: register the packed word and error; hold under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_r <= 1'b0;
      s2_inst_r  <= {INST_WIDTH{1'b0}};
      s2_err_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_inst_r <= pack_s;
        s2_err_r  <= s1_err_r;
      end
    end
  end

  // Count errored results as they are handed off, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if (s2_valid_r && i_imm_pack_ready && s2_err_r && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Scoreboard bench for imm_pack: expected words are queued on accept and
// compared in order on handoff.
module tb_imm_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_model = 0;
  logic        lat_en = 1'b1;
  logic        last_acc;
  logic [32:0] cur_exp;
  logic [32:0] exp_q[$];
  int          t_q[$];

  imm_pack dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_imm_pack_valid   (in_valid),
    .o_imm_pack_ready   (in_ready),
    .i_imm_pack_opcode  (opcode),
    .i_imm_pack_rd      (rd),
    .i_imm_pack_rs1     (rs1),
    .i_imm_pack_rs2     (rs2),
    .i_imm_pack_funct3  (f3),
    .i_imm_pack_imm     (imm),
    .o_imm_pack_valid   (out_valid),
    .i_imm_pack_ready   (out_ready),
    .o_imm_pack_inst    (inst),
    .o_imm_pack_err     (err),
    .o_imm_pack_err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: observe handshakes just after the negedge, then advance.
  task automatic tick();
    logic [32:0] e;
    int t;
    #1;
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        t = t_q.pop_front();
        chk("inst", 64'(inst), 64'(e[31:0]));
        chk("err", 64'(err), 64'(e[32]));
        if (lat_en) chk("latency", 64'(cyc - t), 64'd2);
        if (e[32] && cnt_model < 255) cnt_model++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      t_q.push_back(cyc);
      last_acc = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im,
                      input logic e_err, input logic [31:0] e_inst);
    int n;
    opcode = o; rd = d; rs1 = s1; rs2 = s2; f3 = f; imm = im;
    in_valid = 1'b1;
    cur_exp = {e_err, e_inst};
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 50) begin
      tick();
      n++;
    end
    if (!last_acc) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; f3 = 3'd0; imm = 32'd0;
    cur_exp = 33'd0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // I-type, isolated
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093);
    drain();
    // S and U back to back
    send(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8, 1'b0, 32'h0021_A423);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
    drain();
    // negative branch / jump offsets
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFF8, 1'b0, 32'hFE00_0CE3);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFDF_F06F);
    drain();
    // error cases
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1, 32'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1, 32'd0);
    send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 1'b1, 32'd0);
    drain();
    chk("err_cnt_3", 64'(err_cnt), 64'd3);
    chk("cnt_model_3", 64'(cnt_model), 64'd3);
    // saturation
    for (int i = 0; i < 260; i++) send(7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1, 32'd0);
    drain();
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);

    // backpressure: two fill the pipe, third stalls
    lat_en = 1'b0;
    out_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0, 32'h0010_0093);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2, 1'b0, 32'h0020_0113);
    opcode = 7'h13; rd = 5'd3; rs1 = 5'd0; imm = 32'd3; in_valid = 1'b1;
    cur_exp = {1'b0, 32'h0030_0193};
    #1;
    held = inst;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_inst_hold", 64'(inst), 64'h0010_0093);
      chk("bp_inst_stable", 64'(inst), 64'(held));
      tick();
    end
    out_ready = 1'b1;
    send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3, 1'b0, 32'h0030_0193);
    send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd4, 1'b0, 32'h0040_0213);
    drain();
    lat_en = 1'b1;

    // reset with both stages full
    out_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0, 32'h0050_0093);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1, 32'd0);
    chk("full_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    t_q.delete();
    cnt_model = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("no_stale", 64'(out_valid), 64'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093);
    drain();
    chk("final_cnt", 64'(err_cnt), 64'(cnt_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
